belt_drive_ramp: RTL
====================

Name: belt_drive_ramp

Overview:
- Downstream consumer of the speed-setpoint stage: takes the binary speed setpoint (0.1 km/h units, 0–199) and drives the treadmill belt motor.
- Limits acceleration with a rate-limited ramp, implements an emergency-stop brake with a re-arm interlock, and generates a glitch-free PWM drive whose duty tracks the ramped speed.
- Sits between the setpoint counter and the motor driver pin; also reports the actual speed to the display path.

Parameters:
- MAX_SPEED, 199: setpoint clamp ceiling; a setpoint above it is treated as MAX_SPEED.
- RAMP_DIV, 2500000: clock cycles per 1-unit ramp step in normal operation; 50 ms per step, so 0.1 km/h per 50 ms.
- BRAKE_DIV, 500000: clock cycles per 1-unit step while braking; must be <= RAMP_DIV.
- PWM_DIV, 25: clock cycles per PWM count.
- PWM_TOP, 199: PWM counter terminal value; period is (PWM_TOP+1)*PWM_DIV; requires PWM_TOP >= MAX_SPEED.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low
- speed  in  8  target speed setpoint, binary
- stop_n  in  1  emergency stop, active-low, already synchronised/debounced
- cur_speed  out  8  current ramped speed
- pwm_out  out  1  motor drive PWM, active-high
- state  out  2  0=IDLE 1=RAMP 2=HOLD 3=BRAKE
- at_speed  out  1  high when state==HOLD
- running  out  1  high when cur_speed != 0

Behaviour:
- Reset: reset sampled low on a CLOCK_50 edge clears all registers on that edge.
  - Cleared registers: cur_speed=0, pwm_out=0, state=IDLE, at_speed=0, running=0, all prescalers and PWM counter=0, latched duty=0.
  - Reset mid-ramp or mid-brake aborts immediately; there is no ramp-down on reset.
- Target: tgt = min(speed, MAX_SPEED), evaluated combinationally each cycle. tgt is forced to 0 while in BRAKE.
- Ramp tick: free-running counter 0..RAMP_DIV-1; tick is asserted in the cycle the counter equals RAMP_DIV-1, then it wraps to 0.
- Brake tick: separate free-running counter 0..BRAKE_DIV-1, with the same rule.
- Step rule: on the active tick (ramp tick in RAMP, brake tick in BRAKE), cur_speed moves 1 toward tgt. No step when equal. Steps never overshoot, and cur_speed never leaves 0..MAX_SPEED.
- State transitions, evaluated every cycle; stop_n low has priority over all other conditions:
  - Any state, stop_n==0 -> BRAKE.
  - IDLE: tgt!=0 -> RAMP.
  - RAMP: cur_speed==tgt and tgt!=0 -> HOLD; cur_speed==tgt==0 -> IDLE.
  - HOLD: tgt!=cur_speed -> RAMP.
  - BRAKE: steps down to 0 on brake ticks. Exit to IDLE only when cur_speed==0, stop_n==1 and speed==0 (re-arm interlock). While any of these is false, remain in BRAKE with cur_speed held at 0.
- Setpoint change during RAMP reverses direction at the next tick; there is no intermediate HOLD.
- PWM generation:
  - Prescaler 0..PWM_DIV-1; on its wrap, pwm_cnt increments 0..PWM_TOP, then wraps to 0.
  - duty_q <= cur_speed is loaded only when pwm_cnt wraps to 0, so a mid-period speed change takes effect next period.
  - pwm_out registered: pwm_out <= (pwm_cnt < duty_q). duty 0 gives constant low; duty_q=PWM_TOP+1 is impossible, so there is always one low count per period.
- Outputs at_speed, running and state are registered and consistent with cur_speed in the same cycle.

Test Plan:
- Ramp-up, with RAMP_DIV=4, BRAKE_DIV=1, PWM_DIV=1, PWM_TOP=199, MAX_SPEED=199: from reset, speed=10 -> state=RAMP; cur_speed increments every 4 cycles and reaches 10 after 40 cycles (+/-3 phase); state=HOLD, at_speed=1.
- Clamp: speed=250 -> cur_speed ramps to 199 and holds; never exceeds 199; HOLD reached.
- Reversal: ramping up, at cur_speed=5 set speed=2 -> next tick cur_speed=4, then 3, then 2; HOLD; never reaches 6.
- E-stop: in HOLD at 20, pull stop_n=0 -> BRAKE next cycle; cur_speed decrements every cycle and reaches 0 in 20 cycles.
  - Then release stop_n with speed=20 -> stays BRAKE.
  - Set speed=0 -> IDLE; set speed=20 -> RAMP.
- PWM: cur_speed=50 held -> pwm_out high for exactly 50 of every 200 cycles.
  - Change to 100 mid-period -> current period stays 50, next period 100.
  - cur_speed=0 -> pwm_out constantly 0.
- Reset mid-operation: reset=0 for 1 cycle while at cur_speed=30 and pwm_out high -> next edge: cur_speed=0, pwm_out=0, state=IDLE, running=0.

Source files
------------

// File: rtl/belt_drive_ramp.sv
// Treadmill belt drive: rate-limited speed ramp, emergency brake with re-arm
// interlock, and a period-latched PWM whose duty tracks the ramped speed.
module belt_drive_ramp #(
  parameter int MAX_SPEED = 199,
  parameter int RAMP_DIV  = 2500000,
  parameter int BRAKE_DIV = 500000,
  parameter int PWM_DIV   = 25,
  parameter int PWM_TOP   = 199
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] speed,
  input  logic       stop_n,
  output logic [7:0] cur_speed,
  output logic       pwm_out,
  output logic [1:0] state,
  output logic       at_speed,
  output logic       running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BRAKE = 2'd3
  } state_t;

  localparam int RAMP_W  = (RAMP_DIV > 1)  ? $clog2(RAMP_DIV)  : 1;
  localparam int BRAKE_W = (BRAKE_DIV > 1) ? $clog2(BRAKE_DIV) : 1;
  localparam int PRE_W   = (PWM_DIV > 1)   ? $clog2(PWM_DIV)   : 1;
  localparam int CNT_W   = (PWM_TOP > 255) ? $clog2(PWM_TOP + 1) : 8;

  localparam logic [7:0]         MAX_S      = 8'(MAX_SPEED);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
  localparam logic [BRAKE_W-1:0] BRAKE_LAST = BRAKE_W'(BRAKE_DIV - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PWM_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_TOP    = CNT_W'(PWM_TOP);

  state_t             state_q, state_d;
  logic [7:0]         cur_q, cur_d;
  logic               at_speed_q, at_speed_d;
  logic               running_q, running_d;
  logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic [BRAKE_W-1:0] brake_cnt_q, brake_cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic               pwm_q, pwm_d;

  logic       ramp_tick, brake_tick, step_en, pre_wrap;
  logic [7:0] tgt;

  assign ramp_tick  = (ramp_cnt_q == RAMP_LAST);
  assign brake_tick = (brake_cnt_q == BRAKE_LAST);
  assign pre_wrap   = (pre_q == PRE_LAST);

  // Ramp/brake dividers free-run regardless of state.
  always_comb begin
    ramp_cnt_d  = ramp_tick  ? '0 : ramp_cnt_q + 1'b1;
    brake_cnt_d = brake_tick ? '0 : brake_cnt_q + 1'b1;
  end

  always_comb begin
    tgt        = (speed > MAX_S) ? MAX_S : speed;
    if (state_q == ST_BRAKE) tgt = 8'd0;
    step_en    = ((state_q == ST_RAMP) && ramp_tick) ||
                 ((state_q == ST_BRAKE) && brake_tick);
    cur_d      = cur_q;
    state_d    = state_q;
    if (step_en) begin
      if (cur_q < tgt)      cur_d = cur_q + 8'd1;
      else if (cur_q > tgt) cur_d = cur_q - 8'd1;
    end
    if (!stop_n) begin
      state_d = ST_BRAKE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (tgt != 8'd0) state_d = ST_RAMP;
        ST_RAMP:  if (cur_q == tgt) state_d = (tgt != 8'd0) ? ST_HOLD : ST_IDLE;
        ST_HOLD:  if (tgt != cur_q) state_d = ST_RAMP;
        // Re-arm only once the belt is stopped and the setpoint is back at zero.
        ST_BRAKE: if ((cur_q == 8'd0) && (speed == 8'd0)) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    at_speed_d = (state_d == ST_HOLD);
    running_d  = (cur_d != 8'd0);
  end

  // Duty is latched only at the period boundary so every PWM period is whole.
  always_comb begin
    pre_d     = pre_wrap ? '0 : pre_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    if (pre_wrap) begin
      if (pwm_cnt_q == CNT_TOP) begin
        pwm_cnt_d = '0;
        duty_d    = CNT_W'(cur_q);
      end else begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
    end
    pwm_d = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= 8'd0;
      at_speed_q  <= 1'b0;
      running_q   <= 1'b0;
      ramp_cnt_q  <= '0;
      brake_cnt_q <= '0;
      pre_q       <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      at_speed_q  <= at_speed_d;
      running_q   <= running_d;
      ramp_cnt_q  <= ramp_cnt_d;
      brake_cnt_q <= brake_cnt_d;
      pre_q       <= pre_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
    end
  end

  assign cur_speed = cur_q;
  assign state     = state_q;
  assign at_speed  = at_speed_q;
  assign running   = running_q;
  assign pwm_out   = pwm_q;

endmodule
